// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg: shared widths, grant-source encoding and x0 index
package regfile_write_arbiter_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int REG_X0 = 0;
  typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_LL} gnt_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: WB request, LL handshake and register-file write port bundle
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BUF_DEPTH = 2
);
  logic WB_WE;
  logic [ADDR_WIDTH-1:0] WB_A;
  logic [DATA_WIDTH-1:0] WB_WD;
  logic WB_STALL;
  logic LL_VALID;
  logic LL_READY;
  logic [ADDR_WIDTH-1:0] LL_A;
  logic [DATA_WIDTH-1:0] LL_WD;
  logic WE3;
  logic [ADDR_WIDTH-1:0] A3;
  logic [DATA_WIDTH-1:0] WD3;
  logic [$clog2(BUF_DEPTH+1)-1:0] BUF_COUNT;
  modport master (
    output WB_WE, WB_A, WB_WD, LL_VALID, LL_A, LL_WD,
    input WB_STALL, LL_READY, WE3, A3, WD3, BUF_COUNT
  );
  modport slave (
    input WB_WE, WB_A, WB_WD, LL_VALID, LL_A, LL_WD,
    output WB_STALL, LL_READY, WE3, A3, WD3, BUF_COUNT
  );
endinterface

// File: rtl/regfile_write_arbiter_sync_fifo.sv
// sync_fifo: circular FIFO with occupancy count, async active-high reset
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0] count,
  output logic full,
  output logic empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  // storage needs no reset: pointers and count alone define which entries are valid
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  // pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  assign dout = mem[rp];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between WB and a buffered long-latency unit
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BUF_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic CLK,
  input logic RST,
  regfile_write_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(REG_X0);
  gnt_t gnt;
  logic wb_req, force_ll, push, pop, full, empty;
  logic [SW-1:0] starve;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;
  sync_fifo #(.WIDTH(ADDR_WIDTH + DATA_WIDTH), .DEPTH(BUF_DEPTH)) u_fifo (
    .clk(CLK),
    .rst(RST),
    .push(push),
    .pop(pop),
    .din({bus.LL_A, bus.LL_WD}),
    .dout(head),
    .count(bus.BUF_COUNT),
    .full(full),
    .empty(empty)
  );
  // forced drain beats WB, WB beats opportunistic drain; x0 traffic is dropped and reset silences the port
  always_comb begin
    wb_req = bus.WB_WE && bus.WB_A != X0;
    force_ll = !empty && starve == SW'(STARVE_LIMIT);
    gnt = RST ? GNT_NONE : force_ll ? GNT_LL : wb_req ? GNT_WB : !empty ? GNT_LL : GNT_NONE;
    pop = gnt == GNT_LL;
    bus.LL_READY = !RST && !full;
    push = bus.LL_VALID && bus.LL_READY && bus.LL_A != X0;
    bus.WB_STALL = !RST && force_ll && wb_req;
    bus.WE3 = gnt != GNT_NONE;
    bus.A3 = gnt == GNT_WB ? bus.WB_A : gnt == GNT_LL ? head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH] : '0;
    bus.WD3 = gnt == GNT_WB ? bus.WB_WD : gnt == GNT_LL ? head[DATA_WIDTH-1:0] : '0;
  end
  // age of the waiting FIFO head, saturating at the limit that forces a drain
  always_ff @(posedge CLK or posedge RST)
    if (RST) starve <= '0;
    else starve <= pop || empty ? '0 : starve == SW'(STARVE_LIMIT) ? starve : starve + 1'b1;
endmodule
